// File: rtl/arm_boot_loader.sv
// arm_boot_loader: receives a framed program image as a byte stream, packs
// little-endian 32-bit words into instruction memory and holds the core in
// reset until the frame checksum matches.
//
// Frame: 0xA5, LEN_LO, LEN_HI (word count N), 4*N data bytes, CHK.
// CHK is the XOR of LEN_LO, LEN_HI and every data byte.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is no
// ready/back-pressure, so every strobed byte is consumed in the cycle it
// arrives, including strobes on consecutive cycles.
//
// ADDR_W must be at most 15 so that a word index fits the 16-bit length field.
module arm_boot_loader #(
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      CAPACITY  = 17'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          chk_q, chk_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [23:0]         acc_q, acc_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [15:0]         n_rx;
  logic                in_frame;
  logic                last_word;

  // Word count as it would read once the high length byte is taken.
  assign n_rx      = {rx_data, len_q[7:0]};
  // States in which a stalled sender is detected by the idle timer.
  assign in_frame  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
  assign last_word = (16'(word_idx_q) == (len_q - 16'd1));

  // Next-state and datapath update for frame parsing, packing and checksum.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    acc_d      = acc_q;
    tmo_d      = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (in_frame && !rx_valid) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          chk_d      = chk_q ^ rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          chk_d       = chk_q ^ rx_data;
          word_idx_d  = '0;
          byte_cnt_d  = 2'd0;
          if (n_rx == 16'd0)                   state_d = S_CHECK;
          else if ({1'b0, n_rx} > CAPACITY)    state_d = S_ERROR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          chk_d      = chk_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: acc_d[7:0]   = rx_data;
            2'd1: acc_d[15:8]  = rx_data;
            2'd2: acc_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = word_idx_q;
              wdata_d = {rx_data, acc_q};
              if (last_word) state_d = S_CHECK;
              else           word_idx_d = word_idx_q + ADDR_W'(1);
            end
          endcase
        end
      end
      S_CHECK: begin
        if (rx_valid) state_d = (rx_data == chk_q) ? S_RUN : S_ERROR;
      end
      S_RUN, S_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      default: state_d = S_IDLE;
    endcase

    // A sender that goes quiet mid-frame abandons the image.
    if (in_frame && !rx_valid && tmo_q == TMO_LAST) state_d = S_ERROR;

    // Every new frame starts from a clean checksum, counters and timer.
    if (state_d == S_LEN_LO && state_q != S_LEN_LO) begin
      len_d      = '0;
      chk_d      = '0;
      byte_cnt_d = 2'd0;
      word_idx_d = '0;
      acc_d      = '0;
      tmo_d      = '0;
    end
  end

  // State and datapath registers; reset abandons any partial image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      chk_q      <= '0;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset   = (state_q != S_RUN);
  assign done        = (state_q == S_RUN);
  assign error       = (state_q == S_ERROR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arm_boot_loader.sv
// tb_arm_boot_loader: directed frames against arm_boot_loader, with imem
// writes checked against an expected queue filled as bytes are driven.
module tb_arm_boot_loader;

  localparam int ADDR_W = 6;
  localparam int TMO    = 16;
  localparam int W      = ADDR_W + 32;

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_DATA  = 32'd3;
  localparam logic [31:0] ST_ERROR = 32'd6;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state_o;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int snap;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [31:0]  img[0:63];

  arm_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error),
    .dbg_state_o (dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one byte strobe, returns 1 time unit after the sampling edge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: full frame from img[], pushing expected writes as words complete
  task automatic send_frame(input logic [15:0] n, input bit bad_chk, input bit skip_sync);
    logic [7:0] chk;
    logic [7:0] b;
    if (!skip_sync) send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
    chk = n[7:0] ^ n[15:8];
    for (int w = 0; w < int'(n); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        chk = chk ^ b;
        if (k == 3) exp_q.push_back({ADDR_W'(w), img[w]});
        send(b);
      end
    end
    send(bad_chk ? (chk ^ 8'h01) : chk);
  endtask

  // scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        assert ({imem_addr, imem_wdata} === mon_e) else begin
          bad++;
          $error("FAIL write: observed %h expected %h", {imem_addr, imem_wdata}, mon_e);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("rst_state", 32'(dbg_state_o), ST_IDLE);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;
    idle(2);

    // bytes before sync are ignored
    send(8'h11);
    send(8'h5A);
    check("idle_ignores", 32'(dbg_state_o), ST_IDLE);

    // two-word image
    img[0] = 32'h44332211;
    img[1] = 32'h88776655;
    send_frame(16'd2, 1'b0, 1'b0);
    check("c1_done", 32'(done), 32'd1);
    check("c1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("c1_error", 32'(error), 32'd0);
    check("c1_we_cnt", 32'(we_cnt), 32'd2);
    check("c1_addr", 32'(imem_addr), 32'd1);
    check("c1_wdata", imem_wdata, 32'h88776655);

    // reload from RUN, wrong checksum
    send(8'hA5);
    check("reload_done", 32'(done), 32'd0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    send_frame(16'd2, 1'b1, 1'b1);
    check("c2_error", 32'(error), 32'd1);
    check("c2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("c2_done", 32'(done), 32'd0);

    // recovery from ERROR
    send(8'hA5);
    check("c2_error_clears", 32'(error), 32'd0);
    send_frame(16'd2, 1'b0, 1'b1);
    check("c2_recover_done", 32'(done), 32'd1);

    // oversize image
    snap = we_cnt;
    send(8'hA5);
    send(8'h41);
    send(8'h00);
    check("c3_state", 32'(dbg_state_o), ST_ERROR);
    check("c3_error", 32'(error), 32'd1);
    check("c3_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(4);
    check("c3_no_writes", 32'(we_cnt), 32'(snap));

    // full-capacity image, sync bytes inside data
    for (int w = 0; w < 64; w++) img[w] = $urandom;
    img[0]  = 32'hA5A5A5A5;
    img[63] = 32'hDEADBEEF;
    snap = we_cnt;
    send_frame(16'd64, 1'b0, 1'b0);
    check("cap_done", 32'(done), 32'd1);
    check("cap_we_cnt", 32'(we_cnt), 32'(snap + 64));
    check("cap_addr", 32'(imem_addr), 32'd63);
    check("cap_wdata", imem_wdata, 32'hDEADBEEF);

    // empty image
    snap = we_cnt;
    send_frame(16'd0, 1'b0, 1'b0);
    check("c4_done", 32'(done), 32'd1);
    check("c4_no_writes", 32'(we_cnt), 32'(snap));
    send_frame(16'd0, 1'b1, 1'b0);
    check("c4_bad_error", 32'(error), 32'd1);
    check("c4_bad_done", 32'(done), 32'd0);

    // timeout after one data byte
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h11);
    idle(TMO - 1);
    check("c5_before", 32'(error), 32'd0);
    check("c5_state_before", 32'(dbg_state_o), ST_DATA);
    idle(1);
    check("c5_timeout", 32'(error), 32'd1);

    // asynchronous reset mid-frame, then a clean back-to-back reload
    img[0] = 32'h44332211;
    img[1] = 32'h88776655;
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    reset = 1'b1;
    #1;
    check("c6_state", 32'(dbg_state_o), ST_IDLE);
    check("c6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("c6_done", 32'(done), 32'd0);
    check("c6_error", 32'(error), 32'd0);
    check("c6_we", 32'(imem_we), 32'd0);
    check("c6_addr", 32'(imem_addr), 32'd0);
    check("c6_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    snap = we_cnt;
    send_frame(16'd2, 1'b0, 1'b0);
    check("c6_done_after", 32'(done), 32'd1);
    check("c6_we_cnt", 32'(we_cnt), 32'(snap + 2));
    check("c6_addr_after", 32'(imem_addr), 32'd1);
    check("c6_wdata_after", imem_wdata, 32'h88776655);

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
